// File: rtl/base_sram_cntrs_rc.sv
// Bank of n event counters in a 1R1W SRAM fed by per-channel staging registers; odd slots flush, even slots serve host reads.
// Host read accepted at t returns data at t+2; i_rd_r drops while first pass runs or the 2-entry output buffer is full.
module base_sram_cntrs_rc #(
  parameter int width      = 32,
  parameter int n          = 16,
  parameter int addr_width = $clog2(n),
  parameter int inc_width  = 1,
  parameter bit sat        = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [n*inc_width-1:0] i_inc,
  input  logic                   i_rd_v,
  output logic                   i_rd_r,
  input  logic [addr_width-1:0]  i_rd_a,
  input  logic                   i_rd_clr,
  output logic                   o_rd_v,
  input  logic                   o_rd_r,
  output logic [width-1:0]       o_rd_d
);
  localparam int stg_w = inc_width + addr_width + 2;
  localparam int sum_w = ((width > stg_w) ? width : stg_w) + 1;
  localparam logic [sum_w-1:0] sum_max = (sum_w'(1) << width) - sum_w'(1);

  logic                  slot_q;
  logic                  first_pass_q;
  logic [addr_width-1:0] ptr_q;
  logic [stg_w-1:0]      stg_q [n];
  logic [stg_w-1:0]      stg_d [n];

  logic                  fl_vld_q;
  logic                  fl_first_q;
  logic [addr_width-1:0] fl_addr_q;
  logic [stg_w-1:0]      fl_cap_q;

  logic                  hs_vld_q;
  logic                  hs_clr_q;
  logic                  hs_oob_q;
  logic [addr_width-1:0] hs_addr_q;

  logic [width-1:0]      mem [n];
  logic [width-1:0]      rd_dat_q;

  logic [width-1:0]      buf_q [2];
  logic                  buf_wr_q;
  logic                  buf_rd_q;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;

  logic                  host_acc;
  logic                  in_rng;
  logic                  rd_en;
  logic [addr_width-1:0] rd_addr;
  logic                  wr_en;
  logic [addr_width-1:0] wr_addr;
  logic [width-1:0]      wr_dat;
  logic [sum_w-1:0]      fl_sum;
  logic [width-1:0]      fl_dat;
  logic                  push;
  logic                  pop;
  logic [width-1:0]      push_dat;

  assign in_rng   = int'(i_rd_a) < n;
  assign i_rd_r   = ~slot_q & ~first_pass_q & (cnt_q != 2'd2);
  assign host_acc = i_rd_v & i_rd_r;
  assign rd_en    = slot_q | host_acc;
  assign rd_addr  = slot_q ? ptr_q : i_rd_a;

  // First pass ignores whatever the uninitialised SRAM holds.
  always_comb begin
    fl_sum = (fl_first_q ? '0 : sum_w'(rd_dat_q)) + sum_w'(fl_cap_q);
    if (sat && (fl_sum > sum_max)) fl_dat = width'(sum_max);
    else                           fl_dat = fl_sum[width-1:0];
  end

  // Flush writes land in even slots, clears in odd slots, so one write port suffices.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = fl_addr_q;
    wr_dat  = fl_dat;
    if (fl_vld_q) begin
      wr_en = 1'b1;
    end else if (hs_vld_q && hs_clr_q && !hs_oob_q) begin
      wr_en   = 1'b1;
      wr_addr = hs_addr_q;
      wr_dat  = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < n; i++) begin
      stg_d[i] = ((slot_q && (ptr_q == addr_width'(i))) ? '0 : stg_q[i])
               + stg_w'(i_inc[i*inc_width +: inc_width]);
    end
  end

  // Read data forwards a same-cycle write to the same address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat_q <= (wr_en && (wr_addr == rd_addr)) ? wr_dat : mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q       <= 1'b0;
      first_pass_q <= 1'b1;
      ptr_q        <= '0;
      for (int i = 0; i < n; i++) stg_q[i] <= '0;
      fl_vld_q     <= 1'b0;
      fl_first_q   <= 1'b0;
      fl_addr_q    <= '0;
      fl_cap_q     <= '0;
      hs_vld_q     <= 1'b0;
      hs_clr_q     <= 1'b0;
      hs_oob_q     <= 1'b0;
      hs_addr_q    <= '0;
    end else begin
      slot_q   <= ~slot_q;
      stg_q    <= stg_d;
      fl_vld_q <= slot_q;
      hs_vld_q <= host_acc;
      if (slot_q) begin
        fl_addr_q  <= ptr_q;
        fl_cap_q   <= stg_q[ptr_q];
        fl_first_q <= first_pass_q;
        if (ptr_q == addr_width'(n - 1)) begin
          ptr_q        <= '0;
          first_pass_q <= 1'b0;
        end else begin
          ptr_q <= ptr_q + addr_width'(1);
        end
      end
      if (host_acc) begin
        hs_addr_q <= i_rd_a;
        hs_clr_q  <= i_rd_clr;
        hs_oob_q  <= ~in_rng;
      end
    end
  end

  assign push     = hs_vld_q;
  assign pop      = o_rd_v & o_rd_r;
  assign push_dat = hs_oob_q ? '0 : rd_dat_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      buf_wr_q <= 1'b0;
      buf_rd_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        buf_q[buf_wr_q] <= push_dat;
        buf_wr_q        <= ~buf_wr_q;
      end
      if (pop) buf_rd_q <= ~buf_rd_q;
    end
  end

  assign o_rd_v = (cnt_q != 2'd0);
  assign o_rd_d = buf_q[buf_rd_q];

endmodule
